// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: micro-op codes,
// FSM states, big-endian byte-enable constants and decode helpers.
package mem_access_stage_pkg;

  localparam int ALUOP_W = 8;
  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALUOP_NOP = 8'h00;
  localparam aluop_t ALUOP_ADD = 8'h18;
  localparam aluop_t ALUOP_LB  = 8'h90;
  localparam aluop_t ALUOP_LBU = 8'h91;
  localparam aluop_t ALUOP_LH  = 8'h92;
  localparam aluop_t ALUOP_LHU = 8'h93;
  localparam aluop_t ALUOP_LW  = 8'h94;
  localparam aluop_t ALUOP_SB  = 8'h98;
  localparam aluop_t ALUOP_SH  = 8'h99;
  localparam aluop_t ALUOP_SW  = 8'h9a;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_t;

  // Lane 3 ([31:24]) holds the lowest address: big-endian byte order.
  localparam logic [3:0] BE_B0 = 4'b1000;
  localparam logic [3:0] BE_B1 = 4'b0100;
  localparam logic [3:0] BE_B2 = 4'b0010;
  localparam logic [3:0] BE_B3 = 4'b0001;
  localparam logic [3:0] BE_H0 = 4'b1100;
  localparam logic [3:0] BE_H2 = 4'b0011;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic size_t access_size(input aluop_t op);
    case (op)
      ALUOP_LB, ALUOP_LBU, ALUOP_SB: return SZ_BYTE;
      ALUOP_LH, ALUOP_LHU, ALUOP_SH: return SZ_HALF;
      ALUOP_LW, ALUOP_SW:            return SZ_WORD;
      default:                       return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_load(input aluop_t op);
    return (op == ALUOP_LB) || (op == ALUOP_LBU) || (op == ALUOP_LH) ||
           (op == ALUOP_LHU) || (op == ALUOP_LW);
  endfunction

  function automatic logic is_store(input aluop_t op);
    return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage_store_lane_align.sv
// Combinational lane steering: micro-op, address offset and store data to
// byte enables, byte-swapped write data and a misalignment flag.
module store_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         offset,
  input  logic [31:0]        rt,
  output logic [3:0]         be,
  output logic [31:0]        wdata,
  output logic               misalign
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    be       = '0;
    wdata    = '0;
    misalign = 1'b0;
    case (access_size(aluop))
      SZ_BYTE: begin
        case (offset)
          2'd0: begin be = BE_B0; wdata = {rt[7:0], 24'h0}; end
          2'd1: begin be = BE_B1; wdata = {8'h0, rt[7:0], 16'h0}; end
          2'd2: begin be = BE_B2; wdata = {16'h0, rt[7:0], 8'h0}; end
          default: begin be = BE_B3; wdata = {24'h0, rt[7:0]}; end
        endcase
      end
      SZ_HALF: begin
        if (offset[0]) begin
          misalign = 1'b1;
        end else if (!offset[1]) begin
          be    = BE_H0;
          wdata = {rt[7:0], rt[15:8], 16'h0};
        end else begin
          be    = BE_H2;
          wdata = {16'h0, rt[7:0], rt[15:8]};
        end
      end
      SZ_WORD: begin
        if (offset != 2'd0) begin
          misalign = 1'b1;
        end else begin
          be    = BE_W;
          wdata = {rt[7:0], rt[15:8], rt[23:16], rt[31:24]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues byte-enabled requests on a handshaked
// data bus, stalls until ack, flags misaligned accesses, aborts on timeout.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic               mem_valid_i,
  input  logic [ALUOP_W-1:0] mem_aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_din_i,
  input  logic               flush_i,
  output logic [3:0]         mem_dre_o,
  output logic [31:0]        mem_dm_o,
  output logic               stall_req_o,
  output logic               exc_adel_o,
  output logic               exc_ades_o,
  output logic [31:0]        badvaddr_o,
  output logic               bus_err_o,
  output logic               dbus_req_o,
  output logic               dbus_wr_o,
  output logic [3:0]         dbus_be_o,
  output logic [31:0]        dbus_addr_o,
  output logic [31:0]        dbus_wdata_o,
  input  logic [31:0]        dbus_rdata_i,
  input  logic               dbus_ack_i
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [3:0]  be;
  logic [31:0] wdata;
  logic        misalign;

  store_lane_align u_align (
    .aluop    (mem_aluop_i),
    .offset   (mem_addr_i[1:0]),
    .rt       (mem_din_i),
    .be       (be),
    .wdata    (wdata),
    .misalign (misalign)
  );

  logic op_load;
  logic op_store;
  assign op_load  = is_load(mem_aluop_i);
  assign op_store = is_store(mem_aluop_i);

  state_t           state;
  logic             req_wr;
  logic             req_load;
  logic [3:0]       req_be;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [31:0]      mem_dm_q;
  logic [CNT_W-1:0] wd_cnt;
  logic             bus_err_q;

  logic req_active;
  logic start;
  logic wd_expire;

  assign req_active = (state == ST_WAIT) || (state == ST_DRAIN);

  // The cycle after a watchdog abort the failed instruction is still in MEM;
  // suppressing start there lets it retire instead of re-issuing.
  assign start = (state == ST_IDLE) && mem_valid_i && (op_load || op_store) &&
                 !misalign && !flush_i && !bus_err_q;

  assign wd_expire = (TIMEOUT != 0) && req_active && !dbus_ack_i && (wd_cnt == WD_LAST);

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= ST_IDLE;
      req_wr    <= 1'b0;
      req_load  <= 1'b0;
      req_be    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      mem_dm_q  <= '0;
      wd_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT;
            req_wr    <= op_store;
            req_load  <= op_load;
            req_be    <= be;
            req_addr  <= {mem_addr_i[31:2], 2'b00};
            req_wdata <= op_store ? wdata : '0;
            wd_cnt    <= '0;
          end
        end
        ST_WAIT: begin
          if (dbus_ack_i) begin
            if (flush_i) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DONE;
              if (req_load) mem_dm_q <= dbus_rdata_i;
            end
          end else if (wd_expire) begin
            state     <= ST_IDLE;
            bus_err_q <= 1'b1;
            mem_dm_q  <= '0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
            if (flush_i) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The slave has already seen the request; hold it until it completes.
          if (dbus_ack_i) begin
            state <= ST_IDLE;
          end else if (wd_expire) begin
            state     <= ST_IDLE;
            bus_err_q <= 1'b1;
            mem_dm_q  <= '0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall_req_o  = start || req_active;
  assign dbus_req_o   = req_active;
  assign dbus_wr_o    = req_wr;
  assign dbus_be_o    = req_be;
  assign dbus_addr_o  = req_addr;
  assign dbus_wdata_o = req_wdata;
  assign mem_dm_o     = mem_dm_q;
  assign bus_err_o    = bus_err_q;

  assign mem_dre_o  = (mem_valid_i && op_load) ? be : 4'b0000;
  assign exc_adel_o = mem_valid_i && op_load && misalign;
  assign exc_ades_o = mem_valid_i && op_store && misalign;
  assign badvaddr_o = (exc_adel_o || exc_ades_o) ? mem_addr_i : 32'h0;

endmodule
